disparity_monitor: RTL and testbench
====================================

// Module: disparity_monitor
// PURPOSE
//  Downstream consumer of the bitbalancer popcount stage. Converts each 4-bit
//  per-byte ones-count into a signed byte disparity (2*count-8) and accumulates
//  a saturating running disparity over a frame of FRAME_LEN bytes. At frame end
//  it reports the final disparity and an imbalance flag through a valid/ready
//  result port. Used for DC-balance checking of byte streams.
// PARAMETERS
//  FRAME_LEN  16  bytes per frame (>=2)
//  RD_W       8   width of signed running-disparity accumulator (>=5)
//  THRESH     12  imbalance threshold; flag when |final rd| > THRESH
// PORTS
//  clk          in   1     clock, all logic on posedge
//  reset        in   1     synchronous, active-high reset
//  in_valid     in   1     count beat valid
//  in_ready     out  1     block accepts beat; beat taken when in_valid&in_ready
//  count        in   4     ones-count of one byte, legal 0..8
//  frame_start  in   1     restart frame (qualified by in_valid&in_ready)
//  res_valid    out  1     result valid; held until res_ready
//  res_ready    in   1     result consumer ready
//  res_rd       out  RD_W  signed final running disparity (two's complement)
//  res_imbal    out  1     |res_rd| > THRESH
//  res_sat      out  1     accumulator saturated at any point in frame
//  busy         out  1     high in ACCUM or REPORT
// BEHAVIOUR
//  - Reset (sync): state=IDLE, acc=0, beat_cnt=0, sat=0; res_valid=0,
//    res_rd=0, res_imbal=0, res_sat=0, busy=0, in_ready=1. Reset mid-frame or
//    mid-REPORT discards everything; no result emitted for that frame.
//  - Byte disparity d = 2*count-8, range -8..+8; count 9..15 clamped to 8.
//  - acc update: acc_next = sat_add(acc, d); saturates at +(2^(RD_W-1)-1) and
//    -(2^(RD_W-1)-1) (symmetric); any clip sets sat sticky for the frame.
//  - FSM:
//    IDLE:   in_ready=1. On accepted beat: acc=d, beat_cnt=1, -> ACCUM
//            (frame_start optional here; first beat always starts a frame).
//    ACCUM:  in_ready=1, busy=1. Accepted beat with frame_start=1: partial
//            frame dropped, acc=d, beat_cnt=1, sat=0. Otherwise accumulate,
//            beat_cnt++. Beat that makes beat_cnt==FRAME_LEN -> REPORT.
//    REPORT: in_ready=0, res_valid=1, busy=1; res_* registered, stable while
//            res_valid&!res_ready. On res_valid&res_ready -> IDLE, acc=0,
//            sat=0, res_valid=0 next cycle. frame_start ignored.
//  - Latency: res_valid rises the cycle after the last beat is accepted.
//  - No beat accepted in REPORT; throughput is FRAME_LEN beats + >=1 cycle.
//  - in_valid gaps in ACCUM are allowed; acc and beat_cnt hold.
//  - res_imbal computed from saturated res_rd: |res_rd| > THRESH.
// CONFIGURATION
//  PEAK_TRACK_EN defined: adds output res_peak [RD_W-1:0] unsigned = max |acc|
//   reached after any beat in the frame (incl. final); reset value 0, reloaded
//   with |d| on frame (re)start, registered with the other res_* fields.
//  PEAK_TRACK_EN undefined: no res_peak port, no peak logic; all else identical.
// TESTING (defaults unless stated)
//  1 16 beats count=4 -> res_rd=0, res_imbal=0, res_sat=0, res_valid 1 cycle
//    after 16th beat.
//  2 16 beats count=5 -> res_rd=+32, res_imbal=1, res_sat=0; 16 beats count=2
//    -> res_rd=-64, res_imbal=1.
//  3 16 beats count=8 -> acc clips at +127 on beat 16: res_rd=127, res_sat=1,
//    res_imbal=1; count=12 beats behave identically (clamp).
//  4 8 beats count=6 then 8 beats count=2 -> res_rd=0, res_imbal=0;
//    PEAK_TRACK_EN: res_peak=32.
//  5 res_ready low 5 cycles in REPORT -> res_valid/res_* stable, in_ready=0,
//    beats not consumed; res_ready high -> IDLE next cycle.
//  6 5 beats count=8 then beat with frame_start=1 and 15 more count=4 ->
//    res_rd=0 after 16 counted beats; reset after 7 beats -> IDLE, no result.

Source files
------------

// File: rtl/disparity_monitor.sv
// Running-disparity monitor: accumulates saturating byte disparity (2*count-8) over
// FRAME_LEN beats and reports it on a valid/ready port. `define PEAK_TRACK_EN adds res_peak.
module disparity_monitor #(
   parameter int FRAME_LEN = 16,
   parameter int RD_W      = 8,
   parameter int THRESH    = 12
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      count,
   input  logic            frame_start,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [RD_W-1:0] res_rd,
   output logic            res_imbal,
   output logic            res_sat,
`ifdef PEAK_TRACK_EN
   output logic [RD_W-1:0] res_peak,
`endif
   output logic            busy
);

   localparam int CNT_W = $clog2(FRAME_LEN + 1);
   localparam logic signed [RD_W:0] SAT_HI   = (RD_W+1)'(2**(RD_W-1) - 1);
   localparam logic signed [RD_W:0] SAT_LO   = -SAT_HI;
   localparam logic [CNT_W-1:0]     LAST_CNT = CNT_W'(FRAME_LEN);
   localparam logic [RD_W-1:0]      THRESH_U = RD_W'(THRESH);

   typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_REPORT} state_e;

   state_e                 state_q;
   logic signed [RD_W-1:0] acc_q;
   logic [CNT_W-1:0]       cnt_q;
   logic                   sat_q;
   logic                   in_ready_q, res_valid_q, busy_q;
   logic [RD_W-1:0]        res_rd_q;
   logic                   res_imbal_q, res_sat_q;

   logic                   accept_c, restart_c, clip_c;
   logic [3:0]             cnt_clamp_c;
   logic signed [5:0]      d_c;
   logic signed [RD_W-1:0] base_acc_c;
   logic signed [RD_W:0]   sum_c;
   logic signed [RD_W-1:0] acc_d;
   logic [RD_W-1:0]        abs_d;
   logic [CNT_W-1:0]       cnt_d;
   logic                   sat_d;
`ifdef PEAK_TRACK_EN
   logic [RD_W-1:0]        peak_q, peak_d, res_peak_q;
`endif

   // A beat in IDLE or one flagged frame_start accumulates from an empty frame.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      clip_c      = 1'b0;
      accept_c    = in_valid && in_ready_q;
      restart_c   = (state_q == ST_IDLE) || frame_start;
      cnt_clamp_c = (count > 4'd8) ? 4'd8 : count;
      d_c         = $signed({1'b0, cnt_clamp_c, 1'b0}) - 6'sd8;
      base_acc_c  = restart_c ? '0 : acc_q;
      sum_c       = (RD_W+1)'(base_acc_c) + (RD_W+1)'(d_c);
      acc_d       = RD_W'(sum_c);
      if (sum_c > SAT_HI) begin
         acc_d  = RD_W'(SAT_HI);
         clip_c = 1'b1;
      end else if (sum_c < SAT_LO) begin
         acc_d  = RD_W'(SAT_LO);
         clip_c = 1'b1;
      end
      abs_d = acc_d[RD_W-1] ? $unsigned(-acc_d) : $unsigned(acc_d);
      sat_d = (restart_c ? 1'b0 : sat_q) | clip_c;
      cnt_d = (restart_c ? '0 : cnt_q) + CNT_W'(1);
`ifdef PEAK_TRACK_EN
      peak_d = (restart_c || abs_d > peak_q) ? abs_d : peak_q;
`endif
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         acc_q       <= '0;
         cnt_q       <= '0;
         sat_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         res_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         res_rd_q    <= '0;
         res_imbal_q <= 1'b0;
         res_sat_q   <= 1'b0;
`ifdef PEAK_TRACK_EN
         peak_q      <= '0;
         res_peak_q  <= '0;
`endif
      end else begin
         case (state_q)
            ST_IDLE, ST_ACCUM: begin
               if (accept_c) begin
                  acc_q  <= acc_d;
                  cnt_q  <= cnt_d;
                  sat_q  <= sat_d;
                  busy_q <= 1'b1;
`ifdef PEAK_TRACK_EN
                  peak_q <= peak_d;
`endif
                  if (cnt_d == LAST_CNT) begin
                     state_q     <= ST_REPORT;
                     in_ready_q  <= 1'b0;
                     res_valid_q <= 1'b1;
                     res_rd_q    <= acc_d;
                     res_imbal_q <= abs_d > THRESH_U;
                     res_sat_q   <= sat_d;
`ifdef PEAK_TRACK_EN
                     res_peak_q  <= peak_d;
`endif
                  end else begin
                     state_q <= ST_ACCUM;
                  end
               end
            end
            ST_REPORT: begin
               if (res_ready) begin
                  state_q     <= ST_IDLE;
                  acc_q       <= '0;
                  cnt_q       <= '0;
                  sat_q       <= 1'b0;
                  in_ready_q  <= 1'b1;
                  res_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
`ifdef PEAK_TRACK_EN
                  peak_q      <= '0;
`endif
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign res_valid = res_valid_q;
   assign busy      = busy_q;
   assign res_rd    = res_rd_q;
   assign res_imbal = res_imbal_q;
   assign res_sat   = res_sat_q;
`ifdef PEAK_TRACK_EN
   assign res_peak  = res_peak_q;
`endif

endmodule

// File: tb/tb_disparity_monitor.sv
// Bench for disparity_monitor: directed frame table, corner sequences, and random
// frames checked against a plain-arithmetic model. Honours PEAK_TRACK_EN.
module tb_disparity_monitor;

   localparam int FRAME_LEN = 16;
   localparam int RD_W      = 8;
   localparam int THRESH    = 12;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      count;
   logic            frame_start;
   logic            res_valid;
   logic            res_ready;
   logic [RD_W-1:0] res_rd;
   logic            res_imbal;
   logic            res_sat;
   logic            busy;
`ifdef PEAK_TRACK_EN
   logic [RD_W-1:0] res_peak;
`endif

   disparity_monitor #(.FRAME_LEN(FRAME_LEN), .RD_W(RD_W), .THRESH(THRESH)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .count(count), .frame_start(frame_start), .res_valid(res_valid),
      .res_ready(res_ready), .res_rd(res_rd), .res_imbal(res_imbal),
      .res_sat(res_sat),
`ifdef PEAK_TRACK_EN
      .res_peak(res_peak),
`endif
      .busy(busy)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct { int c1; int n1; int c2; int n2; int rd; int imbal; int sat; int peak; } vec_t;
   typedef struct { int rd; int imbal; int sat; int peak; } res_t;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Reference: running sum of 2*min(c,8)-8 clipped symmetrically to +/-(2^(RD_W-1)-1).
   function automatic res_t model(input int cs[$]);
      int   lim = 2**(RD_W-1) - 1;
      int   acc = 0;
      int   a;
      res_t r   = '{0, 0, 0, 0};
      foreach (cs[i]) begin
         acc += 2 * ((cs[i] > 8) ? 8 : cs[i]) - 8;
         if (acc > lim) begin acc = lim; r.sat = 1; end
         if (acc < -lim) begin acc = -lim; r.sat = 1; end
         a = (acc < 0) ? -acc : acc;
         if (a > r.peak) r.peak = a;
      end
      a       = (acc < 0) ? -acc : acc;
      r.rd    = acc;
      r.imbal = (a > THRESH) ? 1 : 0;
      return r;
   endfunction

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic drive_beat(input int c, input bit fs);
      int t = 0;
      in_valid    = 1'b1;
      count       = 4'(c);
      frame_start = fs;
      while (!in_ready && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_checks++;
         n_fail++;
         $display("FAIL beat_accept_timeout: in_ready low for %0d cycles, expected high", t);
      end
      @(negedge clk);
      in_valid    = 1'b0;
      frame_start = 1'b0;
   endtask

   task automatic send_frame(input int c1, input int n1, input int c2, input int n2);
      for (int i = 0; i < n1; i++) drive_beat(c1, 1'b0);
      for (int i = 0; i < n2; i++) drive_beat(c2, 1'b0);
   endtask

   // Called right after the last beat: checks latency, fields, hold stability, handshake.
   task automatic collect(input string tag, input res_t exp, input int hold);
      check({tag, " latency res_valid"}, int'(res_valid), 1);
      check({tag, " busy"}, int'(busy), 1);
      check({tag, " res_rd"}, int'($signed(res_rd)), exp.rd);
      check({tag, " res_imbal"}, int'(res_imbal), exp.imbal);
      check({tag, " res_sat"}, int'(res_sat), exp.sat);
`ifdef PEAK_TRACK_EN
      check({tag, " res_peak"}, int'(res_peak), exp.peak);
`endif
      res_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, " hold res_valid"}, int'(res_valid), 1);
         check({tag, " hold in_ready"}, int'(in_ready), 0);
         check({tag, " hold res_rd"}, int'($signed(res_rd)), exp.rd);
         check({tag, " hold res_sat"}, int'(res_sat), exp.sat);
      end
      res_ready = 1'b1;
      in_valid  = 1'b0;
      @(negedge clk);
      res_ready = 1'b0;
      check({tag, " post res_valid"}, int'(res_valid), 0);
      check({tag, " post busy"}, int'(busy), 0);
      check({tag, " post in_ready"}, int'(in_ready), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[$];
      res_t exp;
      int   q[$];
      int   seen;
      int   mode, c;
      bit   fs;

      vecs.push_back('{4, 16, 4, 0,    0, 0, 0,   0});
      vecs.push_back('{5, 16, 4, 0,   32, 1, 0,  32});
      vecs.push_back('{2, 16, 4, 0,  -64, 1, 0,  64});
      vecs.push_back('{8, 16, 4, 0,  127, 1, 1, 127});
      vecs.push_back('{12, 16, 4, 0, 127, 1, 1, 127});
      vecs.push_back('{0, 16, 4, 0, -127, 1, 1, 127});
      vecs.push_back('{6, 8, 2, 8,     0, 0, 0,  32});
      vecs.push_back('{3, 10, 7, 6,   16, 1, 0,  20});
      vecs.push_back('{7, 2, 4, 14,   12, 0, 0,  12});
      vecs.push_back('{5, 7, 4, 9,    14, 1, 0,  14});
      vecs.push_back('{1, 2, 4, 14,  -12, 0, 0,  12});

      reset = 1'b1; in_valid = 1'b0; count = '0; frame_start = 1'b0; res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("reset res_valid", int'(res_valid), 0);
      check("reset res_rd", int'(res_rd), 0);
      check("reset res_imbal", int'(res_imbal), 0);
      check("reset res_sat", int'(res_sat), 0);
      check("reset busy", int'(busy), 0);
      check("reset in_ready", int'(in_ready), 1);
      reset = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         send_frame(vecs[i].c1, vecs[i].n1, vecs[i].c2, vecs[i].n2);
         exp = '{vecs[i].rd, vecs[i].imbal, vecs[i].sat, vecs[i].peak};
         collect($sformatf("vec%0d", i), exp, i % 3);
      end

      // Backpressure: a beat offered during REPORT must not be taken.
      send_frame(5, 16, 4, 0);
      in_valid = 1'b1; count = 4'd8;
      collect("backpressure", '{32, 1, 0, 32}, 5);
      send_frame(4, 16, 4, 0);
      collect("after_backpressure", '{0, 0, 0, 0}, 0);

      // Restart mid-frame drops the partial frame and its saturation history.
      send_frame(8, 5, 4, 0);
      check("restart busy", int'(busy), 1);
      drive_beat(4, 1'b1);
      send_frame(4, 15, 4, 0);
      collect("restart", '{0, 0, 0, 0}, 1);

      // Reset mid-frame: no result may ever appear for that frame.
      send_frame(8, 7, 4, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midframe_reset busy", int'(busy), 0);
      check("midframe_reset in_ready", int'(in_ready), 1);
      seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (res_valid) seen++;
      end
      check("midframe_reset no result", seen, 0);

      // Reset during REPORT drops the pending result.
      send_frame(5, 16, 4, 0);
      check("midreport pre res_valid", int'(res_valid), 1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midreport_reset res_valid", int'(res_valid), 0);
      check("midreport_reset res_rd", int'(res_rd), 0);
      send_frame(2, 16, 4, 0);
      collect("after_midreport", '{-64, 1, 0, 64}, 0);

      // Random frames with gaps, occasional restarts and variable result backpressure.
      for (int f = 0; f < 40; f++) begin
         q.delete();
         mode = $urandom_range(0, 2);
         while (q.size() < FRAME_LEN) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            case (mode)
               0:       c = $urandom_range(0, 15);
               1:       c = $urandom_range(6, 12);
               default: c = $urandom_range(0, 3);
            endcase
            fs = (q.size() > 0) && ($urandom_range(0, 19) == 0);
            if (fs) q.delete();
            q.push_back(c);
            drive_beat(c, fs);
         end
         exp = model(q);
         collect($sformatf("rand%0d", f), exp, $urandom_range(0, 3));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
